nn_feeder: RTL and testbench
============================

# nn_feeder

Front-end driver for the `nn` digit classifier. It turns a host pixel stream into the 784-bit binarized image and pulses `Start`. It then waits for `resp`, captures the 5-bit prediction, and hands it back to the host through a valid/ready result port. It sits between the frame source (camera/SDRAM reader) and `nn`, acting as the initiator side of `nn`'s Start/resp handshake.

## Interface
- `THRESH`, default 8'd128: pixel binarization threshold; a pixel ≥ `THRESH` becomes bit 1.
- `NPIX`, default 784: pixels per frame (28×28, row-major).
- `TIMEOUT_CYCLES`, default 4096: watchdog limit in the WAIT state (used only with `NN_FEEDER_TIMEOUT_EN`).
- `Clk`  in  1  system clock, rising edge.
- `Rst`  in  1  asynchronous, active-low reset.
- `pix_valid`  in  1  pixel on `pix_data` is valid.
- `pix_sof`  in  1  qualifies the current pixel as the first of a frame.
- `pix_data`  in  8  grayscale pixel.
- `pix_ready`  out  1  feeder accepts a pixel this cycle.
- `nn_data`  out  784  image to `nn.data`; bit i = pixel i.
- `nn_start`  out  1  one-cycle Start pulse to `nn`.
- `nn_resp`  in  1  `nn` done pulse.
- `nn_prediction`  in  5  `nn` argmax output, valid while `nn_resp`=1.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  host consumes the result.
- `res_digit`  out  5  captured prediction.
- `res_err`  out  1  result is a timeout error.
- `busy`  out  1  high in any state but COLLECT.

## Operation
- States: COLLECT, FULL, START, WAIT.
- **COLLECT**
  - `pix_ready`=1.
  - Accept = `pix_valid & pix_ready`.
  - On accept, write bit `idx` of the image register with `(pix_data >= THRESH)`, then `idx`++.
  - `pix_sof` on an accept forces the write to bit 0, discards any partial frame, and sets `idx`=1.
  - `pix_sof`=0 while `idx`=0 is accepted as pixel 0; no sof is required for the first frame.
  - On the accept that writes bit `NPIX-1`:
    - go to START if the result slot is free (`res_valid`=0, or `res_valid & res_ready` this cycle);
    - otherwise go to FULL.
  - `idx` returns to 0.
- **FULL**
  - `pix_ready`=0.
  - Go to START once the result slot is free.
- **START**
  - `nn_start`=1 for exactly this cycle.
  - Clear the watchdog counter and go to WAIT.
- **WAIT**
  - `pix_ready`=0.
  - On `nn_resp`: `res_digit`←`nn_prediction`, `res_err`←0, `res_valid`←1, go to COLLECT.
- `nn_data` is the image register. It is held constant from entry to START until `nn_resp`, because `nn` reads it throughout.
- Result port:
  - `res_valid` stays 1 until `res_valid & res_ready`, then clears.
  - `res_digit`/`res_err` are stable while `res_valid`=1.
- `nn_resp` outside WAIT is ignored.
- `pix_valid` while `pix_ready`=0: no effect; the pixel is not consumed.

## Timing
- Reset values:
  - state=COLLECT, `idx`=0, `nn_data`=0;
  - `nn_start`=0, `res_valid`=0, `res_digit`=0, `res_err`=0, `busy`=0;
  - `pix_ready`=1 after reset deassertion.
- All outputs are registered except `pix_ready` and `busy`, which decode from the state register.
- Last pixel accept at cycle N with a free slot: `nn_start`=1 at N+1, WAIT from N+2.
- `nn_resp` at cycle M: `res_valid`=1 and `pix_ready`=1 at M+1.
- Throughput: one pixel per cycle in COLLECT.
- Reset asserted mid-frame or mid-WAIT:
  - immediate return to reset values;
  - a pending result is lost;
  - `nn` must share the reset.

## Configuration
- `NN_FEEDER_TIMEOUT_EN` defined:
  - a counter runs in WAIT;
  - when it reaches `TIMEOUT_CYCLES` without `nn_resp`: `res_valid`←1, `res_err`←1, `res_digit`←5'h1F, go to COLLECT;
  - a late `nn_resp` is ignored.
- Not defined:
  - no counter is instantiated;
  - WAIT exits only on `nn_resp`;
  - `res_err` is constant 0.

## Test plan
- Full frame, no gaps: 784 pixels; pixel 0 = 8'hFF, pixel 783 = 8'h80, all others 8'h7F.
  - `nn_data` = bits 0 and 783 set.
  - `nn_start` one cycle after the last accept.
  - Model `nn_resp` with prediction 5'd7 → `res_valid`=1, `res_digit`=7 the next cycle.
- Partial frame restart: 300 pixels of 8'hFF, then `pix_sof` plus 784 pixels of 8'h00.
  - `nn_data`=0; exactly one `nn_start`.
- Backpressure: hold `res_ready`=0 across two frames.
  - Second frame ends in FULL, `nn_start` is withheld.
  - Assert `res_ready` one cycle → `nn_start` the following cycle.
  - First `res_digit` is unchanged until consumed.
- Stalls: toggle `pix_valid` randomly during a frame, and drive `pix_valid`=1 during WAIT.
  - Exactly 784 accepts; no writes while `pix_ready`=0.
- Reset mid-WAIT: `Rst`=0 for 1 cycle → all outputs at reset values; a `nn_resp` afterward is ignored.
- With `NN_FEEDER_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16: no `nn_resp` → `res_err`=1, `res_digit`=5'h1F, 16 cycles after WAIT entry.

Source files
------------

// File: rtl/nn_feeder.sv
// nn_feeder: binarizes a host pixel stream into nn's 784-bit image, drives nn's Start/resp
// handshake and returns the prediction on a valid/ready port. Watchdog option: NN_FEEDER_TIMEOUT_EN.
//
// state   | meaning
// COLLECT | accepting pixels into the image register
// FULL    | frame complete, waiting for the host to drain the previous result
// START   | one-cycle Start pulse to nn
// WAIT    | image held, waiting for nn_resp (or watchdog expiry)
module nn_feeder #(
    parameter logic [7:0]  THRESH         = 8'd128,
    parameter int unsigned NPIX           = 784,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic            pix_valid,
    input  logic            pix_sof,
    input  logic [7:0]      pix_data,
    output logic            pix_ready,
    output logic [NPIX-1:0] nn_data,
    output logic            nn_start,
    input  logic            nn_resp,
    input  logic [4:0]      nn_prediction,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [4:0]      res_digit,
    output logic            res_err,
    output logic            busy
);

    localparam int IDX_W = $clog2(NPIX);

    typedef enum logic [1:0] {S_COLLECT, S_FULL, S_START, S_WAIT} state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx, wr_idx;
    logic             accept, last_pix, slot_free, resp_take, timeout;

    assign accept    = pix_valid & pix_ready;
    // sof restarts the frame: the pixel lands in bit 0 regardless of idx
    assign wr_idx    = pix_sof ? '0 : idx;
    assign last_pix  = accept && (wr_idx == IDX_W'(NPIX - 1));
    assign slot_free = !res_valid || res_ready;
    assign resp_take = (state == S_WAIT) && nn_resp;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) state <= S_COLLECT;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_COLLECT: if (last_pix) state_nxt = slot_free ? S_START : S_FULL;
            S_FULL:    if (slot_free) state_nxt = S_START;
            S_START:   state_nxt = S_WAIT;
            S_WAIT:    if (resp_take || timeout) state_nxt = S_COLLECT;
            default:   state_nxt = S_COLLECT;
        endcase
    end

    always_comb begin
        pix_ready = (state == S_COLLECT);
        busy      = (state != S_COLLECT);
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            idx      <= '0;
            nn_data  <= '0;
            nn_start <= 1'b0;
        end else begin
            nn_start <= (state_nxt == S_START);
            if (accept) begin
                nn_data[wr_idx] <= (pix_data >= THRESH);
                idx             <= last_pix ? '0 : wr_idx + 1'b1;
            end
        end
    end

`ifdef NN_FEEDER_TIMEOUT_EN
    localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WDOG_W-1:0] wdog;

    // loaded with T-1 in START so expiry lands T cycles after WAIT entry
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst)                                wdog <= '0;
        else if (state == S_START)               wdog <= WDOG_W'(TIMEOUT_CYCLES - 1);
        else if (state == S_WAIT && wdog != '0)  wdog <= wdog - 1'b1;
    end

    assign timeout = (state == S_WAIT) && (wdog == '0) && !nn_resp;
`else
    // no watchdog: the parameter only ties off here
    assign timeout = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            res_valid <= 1'b0;
            res_digit <= '0;
            res_err   <= 1'b0;
        end else if (resp_take) begin
            res_valid <= 1'b1;
            res_digit <= nn_prediction;
            res_err   <= 1'b0;
        end else if (timeout) begin
            res_valid <= 1'b1;
            res_digit <= 5'h1F;
            res_err   <= 1'b1;
        end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_nn_feeder.sv
// Scoreboard bench for nn_feeder: stimulus queues expected images/results, a negedge monitor
// pops and compares on nn_start and on result handshakes; a small nn model answers Start.
module tb_nn_feeder;

    logic         Clk = 1'b0;
    logic         Rst = 1'b0;
    logic         pix_valid = 1'b0, pix_sof = 1'b0;
    logic [7:0]   pix_data = 8'h00;
    logic         pix_ready;
    logic [783:0] nn_data;
    logic         nn_start;
    logic         nn_resp;
    logic [4:0]   nn_prediction;
    logic         res_valid;
    logic         res_ready = 1'b1;
    logic [4:0]   res_digit;
    logic         res_err;
    logic         busy;

    nn_feeder #(.TIMEOUT_CYCLES(16)) dut (
        .Clk(Clk), .Rst(Rst),
        .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_data(pix_data), .pix_ready(pix_ready),
        .nn_data(nn_data), .nn_start(nn_start), .nn_resp(nn_resp), .nn_prediction(nn_prediction),
        .res_valid(res_valid), .res_ready(res_ready), .res_digit(res_digit), .res_err(res_err),
        .busy(busy)
    );

    always #5 Clk = ~Clk;

    int checks = 0, failures = 0;
    int acc_cnt = 0, start_cnt = 0;
    int inj_req = 0;
    logic nn_mute = 1'b0;
    int   nn_lat  = 2;

    logic [783:0] img_q[$];
    logic [4:0]   pred_q[$];
    logic [4:0]   dig_q[$];
    logic         err_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pix_val(input int pat, input int i);
        case (pat)
            0:       return (i == 0) ? 8'hFF : (i == 783) ? 8'h80 : 8'h7F;
            1:       return 8'hFF;
            2:       return 8'h00;
            3:       return (i % 2 == 0) ? 8'h80 : 8'h7F;
            default: return (i % 3 == 0) ? 8'hC0 : 8'h10;
        endcase
    endfunction

    function automatic logic [783:0] exp_img(input int pat);
        logic [783:0] m;
        m = '0;
        case (pat)
            0: begin m[0] = 1'b1; m[783] = 1'b1; end
            1: m = '1;
            2: m = '0;
            3: for (int i = 0; i < 784; i += 2) m[i] = 1'b1;
            default: for (int i = 0; i < 784; i += 3) m[i] = 1'b1;
        endcase
        return m;
    endfunction

    // Monitor: inputs and registered outputs are stable at the falling edge
    initial forever begin
        @(negedge Clk);
        if (Rst && pix_valid && pix_ready) acc_cnt++;
        if (nn_start) begin
            start_cnt++;
            checks++;
            if (img_q.size() == 0) begin
                failures++;
                $display("FAIL img_unexpected_start actual=start required=none");
            end else begin
                logic [783:0] e;
                e = img_q.pop_front();
                if (nn_data !== e) begin
                    failures++;
                    $display("FAIL img actual=%h required=%h", nn_data, e);
                end
            end
        end
        if (res_valid && res_ready) begin
            if (dig_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL res_unexpected actual=%0h required=none", res_digit);
            end else begin
                logic [4:0] ed;
                logic       ee;
                ed = dig_q.pop_front();
                ee = err_q.pop_front();
                chk("res_digit", 32'(res_digit), 32'(ed));
                chk("res_err", 32'(res_err), 32'(ee));
            end
        end
    end

    // nn model: answers each Start after nn_lat cycles with the next queued prediction
    initial begin
        int         inj_ack = 0, wait_left = 0;
        logic       pend = 1'b0, chk_next = 1'b0;
        logic [4:0] cur = '0;
        nn_resp = 1'b0;
        nn_prediction = '0;
        forever begin
            @(posedge Clk);
            #1;
            if (chk_next) begin
                chk("resp_valid_lat", 32'(res_valid), 32'd1);
                chk("resp_ready_lat", 32'(pix_ready), 32'd1);
                chk("resp_digit_lat", 32'(res_digit), 32'(cur));
                chk_next = 1'b0;
            end
            nn_resp = 1'b0;
            if (inj_req != inj_ack) begin
                nn_resp = 1'b1;
                nn_prediction = 5'd30;
                inj_ack++;
            end else if (nn_start && !nn_mute) begin
                if (pred_q.size() == 0) chk("pred_queue", 32'd0, 32'd1);
                else begin
                    cur = pred_q.pop_front();
                    wait_left = nn_lat;
                    pend = 1'b1;
                end
            end else if (pend) begin
                if (wait_left == 0) begin
                    nn_resp = 1'b1;
                    nn_prediction = cur;
                    pend = 1'b0;
                    chk_next = 1'b1;
                end else wait_left--;
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic send_pixel(input logic [7:0] d, input logic sof);
        int g = 0;
        pix_valid = 1'b1;
        pix_data  = d;
        pix_sof   = sof;
        while (!pix_ready && g < 500) begin
            tick();
            g++;
        end
        if (g >= 500) chk("pix_ready_timeout", 32'(pix_ready), 32'd1);
        tick();
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic send_frame(input int pat, input int n, input logic sof_first, input logic gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                pix_valid = 1'b0;
                repeat ($urandom_range(1, 3)) tick();
            end
            send_pixel(pix_val(pat, i), (i == 0) && sof_first);
        end
    endtask

    task automatic wait_drain();
        int g = 0;
        while (dig_q.size() != 0 && g < 300) begin
            tick();
            g++;
        end
        chk("result_drain", 32'(dig_q.size()), 32'd0);
    endtask

    task automatic wait_valid();
        int g = 0;
        while (!res_valid && g < 300) begin
            tick();
            g++;
        end
        chk("res_valid_seen", 32'(res_valid), 32'd1);
    endtask

    task automatic expect_frame(input int pat, input logic [4:0] pred);
        img_q.push_back(exp_img(pat));
        pred_q.push_back(pred);
        dig_q.push_back(pred);
        err_q.push_back(1'b0);
    endtask

    initial begin
        int s0, a0;

        // reset values
        repeat (2) @(posedge Clk);
        #1 Rst = 1'b1;
        tick();
        chk("rst_pix_ready", 32'(pix_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_nn_start", 32'(nn_start), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_digit", 32'(res_digit), 32'd0);
        chk("rst_res_err", 32'(res_err), 32'd0);
        chk("rst_nn_data", 32'(nn_data != '0), 32'd0);

        // full frame without sof, threshold boundary at 0x80/0x7F
        expect_frame(0, 5'd7);
        send_frame(0, 784, 1'b0, 1'b0);
        chk("t1_start_lat", 32'(nn_start), 32'd1);
        tick();
        chk("t1_start_one_cycle", 32'(nn_start), 32'd0);
        chk("t1_busy_wait", 32'(busy), 32'd1);
        chk("t1_pix_ready_wait", 32'(pix_ready), 32'd0);
        wait_drain();

        // partial frame discarded by sof
        s0 = start_cnt;
        expect_frame(2, 5'd12);
        send_frame(1, 300, 1'b1, 1'b0);
        send_frame(2, 784, 1'b1, 1'b0);
        wait_drain();
        chk("t2_start_count", 32'(start_cnt - s0), 32'd1);

        // backpressure: second frame parks in FULL
        res_ready = 1'b0;
        expect_frame(3, 5'd3);
        send_frame(3, 784, 1'b1, 1'b0);
        wait_valid();
        chk("t3_first_digit", 32'(res_digit), 32'd3);
        expect_frame(1, 5'd9);
        s0 = start_cnt;
        send_frame(1, 784, 1'b1, 1'b0);
        chk("t3_full_no_start", 32'(nn_start), 32'd0);
        chk("t3_full_pix_ready", 32'(pix_ready), 32'd0);
        chk("t3_full_busy", 32'(busy), 32'd1);
        repeat (5) tick();
        chk("t3_start_withheld", 32'(start_cnt - s0), 32'd0);
        chk("t3_digit_held", 32'(res_digit), 32'd3);
        chk("t3_valid_held", 32'(res_valid), 32'd1);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("t3_start_after_ready", 32'(nn_start), 32'd1);
        wait_valid();
        res_ready = 1'b1;
        wait_drain();

        // stalls and pix_valid held through WAIT
        a0 = acc_cnt;
        expect_frame(4, 5'd21);
        send_frame(4, 784, 1'b1, 1'b1);
        pix_valid = 1'b1;
        pix_data  = 8'hFF;
        begin
            int g = 0;
            while (busy && g < 300) begin
                tick();
                g++;
            end
        end
        chk("t4_nn_data_held", 32'(nn_data == exp_img(4)), 32'd1);
        pix_valid = 1'b0;
        chk("t4_accepts", 32'(acc_cnt - a0), 32'd784);
        wait_drain();

        // reset mid-WAIT, late resp ignored
        nn_mute = 1'b1;
        img_q.push_back(exp_img(1));
        send_frame(1, 784, 1'b1, 1'b0);
        chk("t5_start", 32'(nn_start), 32'd1);
        repeat (3) tick();
        chk("t5_in_wait", 32'(busy), 32'd1);
        Rst = 1'b0;
        #2;
        chk("t5_rst_pix_ready", 32'(pix_ready), 32'd1);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_nn_data", 32'(nn_data != '0), 32'd0);
        chk("t5_rst_res_valid", 32'(res_valid), 32'd0);
        @(posedge Clk);
        #1 Rst = 1'b1;
        inj_req++;
        repeat (3) tick();
        chk("t5_resp_ignored", 32'(res_valid), 32'd0);
        chk("t5_idle", 32'(busy), 32'd0);
        nn_mute = 1'b0;

`ifdef NN_FEEDER_TIMEOUT_EN
        // watchdog expiry 16 cycles after WAIT entry
        nn_mute = 1'b1;
        img_q.push_back(exp_img(3));
        dig_q.push_back(5'h1F);
        err_q.push_back(1'b1);
        send_frame(3, 784, 1'b1, 1'b0);
        tick();
        chk("t6_wait_entry", 32'(busy), 32'd1);
        repeat (15) tick();
        chk("t6_not_yet", 32'(res_valid), 32'd0);
        tick();
        chk("t6_valid", 32'(res_valid), 32'd1);
        chk("t6_err", 32'(res_err), 32'd1);
        chk("t6_digit", 32'(res_digit), 32'h1F);
        wait_drain();
        nn_mute = 1'b0;
`endif

        // operation resumes after reset
        expect_frame(0, 5'd5);
        send_frame(0, 784, 1'b1, 1'b0);
        wait_drain();
        repeat (3) tick();
        chk("end_img_q", 32'(img_q.size()), 32'd0);
        chk("end_pred_q", 32'(pred_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "time limit");
    end

endmodule
